// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the RAT program-counter sequencer:
// FSM state encoding, PC mux select codes and default vectors.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_INTR  = 2'd2
   } state_t;

   localparam logic [1:0] PCSEL_IMMED = 2'd0;
   localparam logic [1:0] PCSEL_STACK = 2'd1;
   localparam logic [1:0] PCSEL_INTR  = 2'd2;

   localparam int         DEF_PC_W      = 10;
   localparam logic [9:0] DEF_RESET_VEC = 10'h000;
   localparam logic [9:0] DEF_INTR_VEC  = 10'h3FF;

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the RAT core control and the PC sequencer.
// XFER_CNT exists only when PCSEQ_PERF_CNT_EN is defined.
interface pc_sequencer_if #(
   parameter int PC_W = 10
);
   import pc_seq_pkg::*;

   logic            STALL;
   logic            BR_REQ;
   logic [PC_W-1:0] BR_ADDR;
   logic            RET_REQ;
   logic            RETI_REQ;
   logic [PC_W-1:0] STACK_ADDR;
   logic            INT_REQ;
   logic            INT_EN_SET;
   logic            INT_EN_CLR;
   logic [PC_W-1:0] PC;
   logic [1:0]      PC_MUX_SEL;
   logic            PC_LD;
   logic            PC_INC;
   logic            PUSH_PC;
   logic [PC_W-1:0] PUSH_DATA;
   logic            INT_ACK;
   logic            INT_EN;
   logic            FSM_EXEC;
`ifdef PCSEQ_PERF_CNT_EN
   logic [15:0]     XFER_CNT;
`endif

   modport master (
      output STALL, BR_REQ, BR_ADDR, RET_REQ, RETI_REQ, STACK_ADDR,
             INT_REQ, INT_EN_SET, INT_EN_CLR,
      input  PC, PC_MUX_SEL, PC_LD, PC_INC, PUSH_PC, PUSH_DATA,
             INT_ACK, INT_EN, FSM_EXEC
`ifdef PCSEQ_PERF_CNT_EN
      , input XFER_CNT
`endif
   );

   modport slave (
      input  STALL, BR_REQ, BR_ADDR, RET_REQ, RETI_REQ, STACK_ADDR,
             INT_REQ, INT_EN_SET, INT_EN_CLR,
      output PC, PC_MUX_SEL, PC_LD, PC_INC, PUSH_PC, PUSH_DATA,
             INT_ACK, INT_EN, FSM_EXEC
`ifdef PCSEQ_PERF_CNT_EN
      , output XFER_CNT
`endif
   );

endinterface

// File: rtl/pc_next_arb.sv
// Combinational next-PC priority arbiter for one executing instruction:
// RETI/RET (stack) over branch/call (immediate) over sequential increment.
module pc_next_arb
   import pc_seq_pkg::*;
(
   input  logic       go,
   input  logic       reti_req,
   input  logic       ret_req,
   input  logic       br_req,
   output logic [1:0] sel,
   output logic       ld,
   output logic       inc
);

   always_comb begin
      sel = PCSEL_IMMED;
      ld  = 1'b0;
      inc = 1'b0;
      if (go) begin
         if (reti_req || ret_req) begin
            sel = PCSEL_STACK;
            ld  = 1'b1;
         end else if (br_req) begin
            ld  = 1'b1;
         end else begin
            inc = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// RAT program counter and FETCH/EXEC/INTR sequencer with interrupt enable.
// Optional transfer counter (XFER_CNT) under macro PCSEQ_PERF_CNT_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W      = DEF_PC_W,
   parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
   parameter logic [PC_W-1:0] INTR_VEC  = DEF_INTR_VEC
)(
   input  logic          CLK,
   input  logic          RST,
   pc_sequencer_if.slave bus
);

   state_t          state;
   logic [PC_W-1:0] pc_q;
   logic            ie_q;
   logic [PC_W-1:0] pc_nxt;

   logic            in_exec;
   logic            in_intr;
   logic            exec_go;
   logic [1:0]      arb_sel;
   logic            arb_ld;
   logic            arb_inc;
   logic [1:0]      mux_sel;
   logic            pc_ld;

   assign in_exec = (state == ST_EXEC);
   assign in_intr = (state == ST_INTR);
   assign exec_go = in_exec && !bus.STALL;

   pc_next_arb u_arb (
      .go       (exec_go),
      .reti_req (bus.RETI_REQ),
      .ret_req  (bus.RET_REQ),
      .br_req   (bus.BR_REQ),
      .sel      (arb_sel),
      .ld       (arb_ld),
      .inc      (arb_inc)
   );

   // The interrupt vector load is not stallable, so it bypasses the arbiter.
   assign mux_sel = in_intr ? PCSEL_INTR : arb_sel;
   assign pc_ld   = in_intr || arb_ld;

   always_comb begin
      pc_nxt = pc_q;
      if (arb_inc) begin
         pc_nxt = pc_q + PC_W'(1);
      end else if (pc_ld) begin
         case (mux_sel)
            PCSEL_IMMED: pc_nxt = bus.BR_ADDR;
            PCSEL_STACK: pc_nxt = bus.STACK_ADDR;
            default:     pc_nxt = INTR_VEC;
         endcase
      end
   end

   // Interrupt decision uses ie_q as held before this EXEC's enable update.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_FETCH;
         pc_q  <= RESET_VEC;
         ie_q  <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (!bus.STALL) state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (!bus.STALL) begin
                  pc_q <= pc_nxt;
                  if (bus.RETI_REQ)        ie_q <= 1'b1;
                  else if (bus.INT_EN_CLR) ie_q <= 1'b0;
                  else if (bus.INT_EN_SET) ie_q <= 1'b1;
                  state <= (bus.INT_REQ && ie_q) ? ST_INTR : ST_FETCH;
               end
            end
            ST_INTR: begin
               pc_q  <= pc_nxt;
               ie_q  <= 1'b0;
               state <= ST_FETCH;
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

   assign bus.PC         = pc_q;
   assign bus.PC_MUX_SEL = mux_sel;
   assign bus.PC_LD      = pc_ld;
   assign bus.PC_INC     = arb_inc;
   assign bus.PUSH_PC    = in_intr;
   assign bus.PUSH_DATA  = in_intr ? pc_q : '0;
   assign bus.INT_ACK    = in_intr;
   assign bus.INT_EN     = ie_q;
   assign bus.FSM_EXEC   = in_exec;

`ifdef PCSEQ_PERF_CNT_EN
   logic [15:0] xfer_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         xfer_q <= 16'd0;
      end else if (pc_ld && (xfer_q != 16'hFFFF)) begin
         xfer_q <= xfer_q + 16'd1;
      end
   end

   assign bus.XFER_CNT = xfer_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: a reference model predicts the next PC
// and interrupt-enable per instruction; predictions are queued and popped.
`timescale 1ns/1ps
module tb_pc_sequencer;

   logic CLK;
   logic RST;

   pc_sequencer_if #(.PC_W(10)) ifc ();

   pc_sequencer dut (
      .CLK (CLK),
      .RST (RST),
      .bus (ifc.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          total = 0;
   int          bad   = 0;
   logic [9:0]  mdl_pc;
   logic        mdl_ie;
   int unsigned mdl_xfer;
   logic [9:0]  exp_q[$];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_in();
      ifc.STALL      = 1'b0;
      ifc.BR_REQ     = 1'b0;
      ifc.BR_ADDR    = '0;
      ifc.RET_REQ    = 1'b0;
      ifc.RETI_REQ   = 1'b0;
      ifc.STACK_ADDR = '0;
      ifc.INT_REQ    = 1'b0;
      ifc.INT_EN_SET = 1'b0;
      ifc.INT_EN_CLR = 1'b0;
   endtask

   task automatic xfer_bump();
      if (mdl_xfer < 32'hFFFF) mdl_xfer++;
   endtask

   task automatic wait_exec();
      int n = 0;
      while (ifc.FSM_EXEC !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      total++;
      if (ifc.FSM_EXEC !== 1'b1) begin
         bad++;
         $display("FAIL wait_exec: FSM_EXEC=%b required 1 within 8 cycles", ifc.FSM_EXEC);
      end
   endtask

   // One instruction: predicts the EXEC outputs and next PC, and the INTR cycle if taken.
   task automatic do_exec(input logic br, input logic [9:0] ba, input logic ret,
                          input logic reti, input logic [9:0] sa, input logic sei,
                          input logic cli, input logic irq, input logic stall_intr);
      logic [9:0] exp_pc;
      logic [9:0] want;
      logic [1:0] exp_sel;
      logic       exp_ld;
      logic       take_int;
      wait_exec();
      ifc.BR_REQ = br;   ifc.BR_ADDR = ba;   ifc.RET_REQ = ret;  ifc.RETI_REQ = reti;
      ifc.STACK_ADDR = sa; ifc.INT_EN_SET = sei; ifc.INT_EN_CLR = cli; ifc.INT_REQ = irq;
      if (reti || ret) begin exp_pc = sa; exp_sel = 2'd1; exp_ld = 1'b1; end
      else if (br)     begin exp_pc = ba; exp_sel = 2'd0; exp_ld = 1'b1; end
      else             begin exp_pc = mdl_pc + 10'd1; exp_sel = 2'd0; exp_ld = 1'b0; end
      take_int = irq && mdl_ie;
      #1;
      total++; if (ifc.PC !== mdl_pc) begin bad++; $display("FAIL exec_pc: got %h want %h", ifc.PC, mdl_pc); end
      total++; if (ifc.PC_LD !== exp_ld) begin bad++; $display("FAIL exec_ld: got %b want %b", ifc.PC_LD, exp_ld); end
      total++; if (ifc.PC_INC !== !exp_ld) begin bad++; $display("FAIL exec_inc: got %b want %b", ifc.PC_INC, !exp_ld); end
      total++; if (ifc.PC_MUX_SEL !== exp_sel) begin bad++; $display("FAIL exec_sel: got %0d want %0d", ifc.PC_MUX_SEL, exp_sel); end
      total++; if (ifc.PUSH_PC !== 1'b0 || ifc.INT_ACK !== 1'b0) begin bad++; $display("FAIL exec_nopush: push=%b ack=%b want 0 0", ifc.PUSH_PC, ifc.INT_ACK); end
      exp_q.push_back(exp_pc);
      if (exp_ld) xfer_bump();
      if (reti)     mdl_ie = 1'b1;
      else if (cli) mdl_ie = 1'b0;
      else if (sei) mdl_ie = 1'b1;
      step();
      clear_in();
      want = exp_q.pop_front();
      total++; if (ifc.PC !== want) begin bad++; $display("FAIL next_pc: got %h want %h", ifc.PC, want); end
      mdl_pc = want;
      total++; if (ifc.INT_EN !== mdl_ie) begin bad++; $display("FAIL int_en: got %b want %b", ifc.INT_EN, mdl_ie); end
      if (take_int) begin
         if (stall_intr) ifc.STALL = 1'b1;
         #1;
         total++; if (ifc.FSM_EXEC !== 1'b0 || ifc.INT_ACK !== 1'b1) begin bad++; $display("FAIL intr_ack: exec=%b ack=%b want 0 1", ifc.FSM_EXEC, ifc.INT_ACK); end
         total++; if (ifc.PUSH_PC !== 1'b1 || ifc.PUSH_DATA !== mdl_pc) begin bad++; $display("FAIL intr_push: push=%b data=%h want 1 %h", ifc.PUSH_PC, ifc.PUSH_DATA, mdl_pc); end
         total++; if (ifc.PC_MUX_SEL !== 2'd2 || ifc.PC_LD !== 1'b1 || ifc.PC_INC !== 1'b0) begin bad++; $display("FAIL intr_sel: sel=%0d ld=%b inc=%b want 2 1 0", ifc.PC_MUX_SEL, ifc.PC_LD, ifc.PC_INC); end
         exp_q.push_back(10'h3FF);
         mdl_ie = 1'b0;
         xfer_bump();
         step();
         ifc.STALL = 1'b0;
         want = exp_q.pop_front();
         total++; if (ifc.PC !== want) begin bad++; $display("FAIL intr_vec: got %h want %h", ifc.PC, want); end
         mdl_pc = want;
         total++; if (ifc.INT_EN !== 1'b0 || ifc.INT_ACK !== 1'b0 || ifc.PUSH_PC !== 1'b0) begin bad++; $display("FAIL post_intr: ie=%b ack=%b push=%b want 0 0 0", ifc.INT_EN, ifc.INT_ACK, ifc.PUSH_PC); end
      end else begin
         total++; if (ifc.INT_ACK !== 1'b0 || ifc.FSM_EXEC !== 1'b0) begin bad++; $display("FAIL no_intr: ack=%b exec=%b want 0 0", ifc.INT_ACK, ifc.FSM_EXEC); end
      end
   endtask

   task automatic test_reset();
      clear_in();
      RST = 1'b0;
      mdl_pc = 10'h000; mdl_ie = 1'b0; mdl_xfer = 0;
      repeat (2) @(posedge CLK);
      #3;
      total++; if (ifc.PC !== 10'h000 || ifc.INT_EN !== 1'b0) begin bad++; $display("FAIL reset_regs: pc=%h ie=%b want 000 0", ifc.PC, ifc.INT_EN); end
      total++; if (ifc.FSM_EXEC !== 1'b0 || ifc.PC_MUX_SEL !== 2'd0) begin bad++; $display("FAIL reset_state: exec=%b sel=%0d want 0 0", ifc.FSM_EXEC, ifc.PC_MUX_SEL); end
      total++; if ({ifc.PC_LD, ifc.PC_INC, ifc.PUSH_PC, ifc.INT_ACK} !== 4'b0 || ifc.PUSH_DATA !== 10'h000) begin bad++; $display("FAIL reset_pulses: ld/inc/push/ack=%b data=%h want 0000 000", {ifc.PC_LD, ifc.PC_INC, ifc.PUSH_PC, ifc.INT_ACK}, ifc.PUSH_DATA); end
`ifdef PCSEQ_PERF_CNT_EN
      total++; if (ifc.XFER_CNT !== 16'd0) begin bad++; $display("FAIL reset_xfer: got %0d want 0", ifc.XFER_CNT); end
`endif
      RST = 1'b1;
      // SEI so the asynchronous reset below has a set enable to clear.
      do_exec(0, 10'h000, 0, 0, 10'h000, 1, 0, 0, 0);
      wait_exec();
      ifc.BR_REQ = 1'b1; ifc.BR_ADDR = 10'h155;
      #2 RST = 1'b0;
      #1;
      total++; if (ifc.PC !== 10'h000 || ifc.INT_EN !== 1'b0) begin bad++; $display("FAIL async_reset_regs: pc=%h ie=%b want 000 0", ifc.PC, ifc.INT_EN); end
      total++; if (ifc.FSM_EXEC !== 1'b0 || ifc.PC_LD !== 1'b0) begin bad++; $display("FAIL async_reset_state: exec=%b ld=%b want 0 0", ifc.FSM_EXEC, ifc.PC_LD); end
      #2 RST = 1'b1;
      clear_in();
      mdl_pc = 10'h000; mdl_ie = 1'b0; mdl_xfer = 0;
      exp_q.delete();
   endtask

   task automatic test_wrap();
      do_exec(1, 10'h3FE, 0, 0, 10'h000, 0, 0, 0, 0);
      do_exec(0, 10'h000, 0, 0, 10'h000, 0, 0, 0, 0);
      do_exec(0, 10'h000, 0, 0, 10'h000, 0, 0, 0, 0);
   endtask

   task automatic test_priority();
      do_exec(1, 10'h120, 1, 0, 10'h055, 0, 0, 0, 0);
      do_exec(1, 10'h121, 1, 1, 10'h0AA, 0, 1, 0, 0);
   endtask

   task automatic test_interrupt();
      do_exec(1, 10'h040, 0, 0, 10'h000, 0, 0, 1, 1);
   endtask

   task automatic test_sei_delay();
      do_exec(0, 10'h000, 0, 0, 10'h000, 1, 0, 1, 0);
      do_exec(0, 10'h000, 0, 0, 10'h000, 0, 1, 1, 0);
      do_exec(0, 10'h000, 0, 0, 10'h000, 0, 0, 1, 0);
   endtask

   task automatic test_stall();
      logic [9:0] want;
      wait_exec();
      ifc.STALL = 1'b1; ifc.BR_REQ = 1'b1; ifc.BR_ADDR = 10'h2AB;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (ifc.PC_LD !== 1'b0 || ifc.PC_INC !== 1'b0 || ifc.PC_MUX_SEL !== 2'd0) begin bad++; $display("FAIL stall_outs: ld=%b inc=%b sel=%0d want 0 0 0", ifc.PC_LD, ifc.PC_INC, ifc.PC_MUX_SEL); end
         step();
         total++; if (ifc.PC !== mdl_pc || ifc.FSM_EXEC !== 1'b1) begin bad++; $display("FAIL stall_hold: pc=%h exec=%b want %h 1", ifc.PC, ifc.FSM_EXEC, mdl_pc); end
      end
      ifc.STALL = 1'b0;
      exp_q.push_back(10'h2AB);
      xfer_bump();
      #1;
      total++; if (ifc.PC_LD !== 1'b1) begin bad++; $display("FAIL unstall_ld: got %b want 1", ifc.PC_LD); end
      step();
      clear_in();
      want = exp_q.pop_front();
      total++; if (ifc.PC !== want) begin bad++; $display("FAIL unstall_pc: got %h want %h", ifc.PC, want); end
      mdl_pc = want;
      ifc.STALL = 1'b1;
      repeat (2) step();
      total++; if (ifc.FSM_EXEC !== 1'b0 || ifc.PC !== mdl_pc) begin bad++; $display("FAIL fetch_stall: exec=%b pc=%h want 0 %h", ifc.FSM_EXEC, ifc.PC, mdl_pc); end
      ifc.STALL = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         do_exec(1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0), 10'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_priority();
      test_interrupt();
      test_sei_delay();
      test_stall();
      test_back_to_back();
`ifdef PCSEQ_PERF_CNT_EN
      total++; if (ifc.XFER_CNT !== 16'(mdl_xfer)) begin bad++; $display("FAIL xfer_cnt: got %0d want %0d", ifc.XFER_CNT, mdl_xfer); end
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
